// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and dmem, with youngest-match load forwarding.
// Optional in-place store coalescing is enabled by defining DMEM_SB_COALESCE_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_we,
  input  logic                       core_re,
  input  logic [AW-1:0]              core_addr,
  input  logic [31:0]                core_wdata,
  output logic [31:0]                core_rdata,
  output logic                       stall,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid;
  logic [AW-3:0]    addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count_q;

  logic             drain, full, push, pop, coal_hit;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PW-1:0]    fwd_idx;
`ifdef DMEM_SB_COALESCE_EN
  logic [PW-1:0]    fwd_sel;
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign drain = !empty && !core_re;

  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
`ifdef DMEM_SB_COALESCE_EN
    fwd_sel  = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if (valid[fwd_idx] && addr_q[fwd_idx] == core_addr[AW-1:2]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
`ifdef DMEM_SB_COALESCE_EN
        fwd_sel  = fwd_idx;
`endif
      end
    end
  end

`ifdef DMEM_SB_COALESCE_EN
  // A hit on the head being retired this cycle must allocate, or the update is lost.
  assign coal_hit = core_we && fwd_hit && !(drain && fwd_sel == head);
`else
  assign coal_hit = 1'b0;
`endif

  assign stall      = core_we && full && !coal_hit;
  assign push       = core_we && !stall && !coal_hit;
  assign pop        = drain;
  assign core_rdata = (core_re && fwd_hit) ? fwd_data : mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = '0;
    if (drain) begin
      mem_we    = 1'b1;
      mem_addr  = {addr_q[head], 2'b00};
      mem_wdata = data_q[head];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= core_addr[AW-1:2];
      data_q[tail] <= core_wdata;
    end
`ifdef DMEM_SB_COALESCE_EN
    if (coal_hit) data_q[fwd_sel] <= core_wdata;
`endif
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed table-driven bench for dmem_store_buffer with a small dmem model.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we, core_re;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        stall, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  count;
  logic        empty;

  logic [31:0] dmem [256];
  int          wr_count = 0;
  logic        allow_illegal = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .reset(reset), .core_we(core_we), .core_re(core_re),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .count(count), .empty(empty)
  );

  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      dmem[mem_addr[9:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && !allow_illegal)
      assert (!(core_we && core_re)) else $error("illegal store and load in the same cycle");
  end

  typedef struct {
    logic        we, re, ill;
    logic [31:0] addr, wdata;
    logic        stall, mwe;
    logic [31:0] maddr, mwdata, rdata;
    int          cnt;
  } vec_t;

  vec_t vec [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    core_we = we; core_re = re; core_addr = a; core_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    dmem[8'h30] = 32'h1234;   // word 0xC0
    //               we re ill addr   wdata  stall mwe maddr  mwdata rdata cnt
    vec[0]  = '{1, 0, 0, 32'h040, 32'h11, 0, 0, 32'h040, 0,     0,      0};
    vec[1]  = '{0, 0, 0, 32'h200, 0,      0, 1, 32'h040, 32'h11, 0,     1};
    vec[2]  = '{0, 0, 0, 32'h200, 0,      0, 0, 32'h200, 0,     0,      0};
    vec[3]  = '{1, 0, 0, 32'h080, 32'hAA, 0, 0, 32'h080, 0,     0,      0};
    vec[4]  = '{1, 0, 0, 32'h080, 32'hBB, 0, 1, 32'h080, 32'hAA, 0,     1};
    vec[5]  = '{0, 1, 0, 32'h080, 0,      0, 0, 32'h080, 0,     32'hBB, 1};
    vec[6]  = '{0, 1, 0, 32'h0C0, 0,      0, 0, 32'h0C0, 0,     32'h1234, 1};
    vec[7]  = '{0, 1, 0, 32'h080, 0,      0, 0, 32'h080, 0,     32'hBB, 1};
    vec[8]  = '{1, 1, 1, 32'h100, 32'h1,  0, 0, 32'h100, 0,     0,      1};
    vec[9]  = '{1, 1, 1, 32'h104, 32'h2,  0, 0, 32'h104, 0,     0,      2};
    vec[10] = '{1, 1, 1, 32'h108, 32'h3,  0, 0, 32'h108, 0,     0,      3};
    vec[11] = '{1, 1, 1, 32'h10C, 32'h4,  1, 0, 32'h10C, 0,     0,      4};
    vec[12] = '{1, 0, 0, 32'h10C, 32'h4,  1, 1, 32'h080, 32'hBB, 32'hAA, 4};
    vec[13] = '{1, 0, 0, 32'h10C, 32'h4,  0, 1, 32'h100, 32'h1, 0,      3};
    vec[14] = '{0, 0, 0, 32'h000, 0,      0, 1, 32'h104, 32'h2, 0,      3};
    vec[15] = '{0, 0, 0, 32'h000, 0,      0, 1, 32'h108, 32'h3, 0,      2};
    vec[16] = '{0, 1, 0, 32'h10C, 0,      0, 0, 32'h10C, 0,     32'h4,  1};
    vec[17] = '{0, 0, 0, 32'h000, 0,      0, 1, 32'h10C, 32'h4, 0,      1};
    vec[18] = '{0, 0, 0, 32'h10C, 0,      0, 0, 32'h10C, 0,     32'h4,  0};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0C0, 32'h0);
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_addr", mem_addr, 32'h0C0);
    chk("rst_rdata", core_rdata, 32'h1234);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      allow_illegal = vec[i].ill;
      drive(vec[i].we, vec[i].re, vec[i].addr, vec[i].wdata);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vec[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vec[i].cnt == 0));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vec[i].stall));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vec[i].mwe));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].maddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vec[i].mwdata);
      chk($sformatf("v%0d_rdata", i), core_rdata, vec[i].rdata);
    end
    chk("dmem_0x40", dmem[8'h10], 32'h11);
    chk("dmem_0x80", dmem[8'h20], 32'hBB);

    // Asynchronous reset with three stores pending
    allow_illegal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h300 + 32'(i * 4), 32'hC0DE0 + 32'(i));
    end
    @(negedge clk);
    allow_illegal = 1'b0;
    drive(1'b0, 1'b0, 32'h000, 32'h0);
    #1;
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_mem_we", 32'(mem_we), 1);
    #1;
    begin
      int wr_before;
      wr_before = wr_count;
      reset = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_mem_we", 32'(mem_we), 0);
      chk("async_rst_empty", 32'(empty), 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_write_after_rst", 32'(wr_count), 32'(wr_before));
      chk("dmem_0x300", dmem[8'hC0], 0);
    end

    // Duplicate store into a full buffer held off by loads
    allow_illegal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'hA1 + 32'(i));
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h204, 32'h55);
    #1;
    chk("dup_full_count", 32'(count), 4);
`ifdef DMEM_SB_COALESCE_EN
    chk("dup_stall", 32'(stall), 0);
`else
    chk("dup_stall", 32'(stall), 1);
`endif
    @(negedge clk);
    allow_illegal = 1'b0;
    drive(1'b0, 1'b1, 32'h204, 32'h0);
    #1;
    chk("dup_after_count", 32'(count), 4);
`ifdef DMEM_SB_COALESCE_EN
    chk("dup_fwd", core_rdata, 32'h55);
`else
    chk("dup_fwd", core_rdata, 32'hA2);
`endif
    drive(1'b0, 1'b0, 32'h000, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("dup_drained_count", 32'(count), 0);
    chk("dup_dmem_0x200", dmem[8'h80], 32'hA1);
`ifdef DMEM_SB_COALESCE_EN
    chk("dup_dmem_0x204", dmem[8'h81], 32'h55);
`else
    chk("dup_dmem_0x204", dmem[8'h81], 32'hA2);
`endif
    chk("dup_dmem_0x20C", dmem[8'h83], 32'hA4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
